// File: rtl/mod_addsub_pipe.sv
// Multi-lane modular add/sub/neg/pass unit: two-stage valid/ready pipeline with tag passthrough.
// Stage 1 forms a (K+1)-bit raw sum/difference per lane; stage 2 folds it back into [0, q).
module mod_addsub_pipe #(
    parameter int unsigned K     = 54,
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [K-1:0]         q,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [LANES*K-1:0]   in_a,
    input  logic [LANES*K-1:0]   in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*K-1:0]   out_res,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    typedef enum logic [1:0] {
        OpAdd  = 2'b00,
        OpSub  = 2'b01,
        OpNeg  = 2'b10,
        OpPass = 2'b11
    } op_e;

    logic                  s1_valid;
    op_e                   s1_op;
    logic [TAG_W-1:0]      s1_tag;
    logic [LANES-1:0][K:0] s1_sum;
    logic [LANES-1:0][K:0] s1_sum_d;

    logic                  s2_valid;
    logic [LANES*K-1:0]    s2_res;
    logic [LANES*K-1:0]    s2_res_d;
    logic [TAG_W-1:0]      s2_tag;

    logic                  s2_accept;
    logic                  s1_advance;
    logic                  in_fire;

    // Stage 2 can take new data when empty or when its current result leaves this edge.
    assign s2_accept  = !s2_valid || out_ready;
    assign s1_advance = s2_accept;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;

    assign out_valid  = s2_valid;
    assign out_res    = s2_res;
    assign out_tag    = s2_tag;
    assign busy       = s1_valid || s2_valid;

    always_comb begin
        logic [K:0] ext_a;
        logic [K:0] ext_b;
        s1_sum_d = '0;
        ext_a    = '0;
        ext_b    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            ext_a = {1'b0, in_a[i*K +: K]};
            ext_b = {1'b0, in_b[i*K +: K]};
            unique case (op_e'(in_op))
                OpAdd:  s1_sum_d[i] = ext_a + ext_b;
                OpSub:  s1_sum_d[i] = ext_a - ext_b;  // bit K is the borrow
                OpNeg:  s1_sum_d[i] = '0 - ext_b;
                OpPass: s1_sum_d[i] = ext_a;
                default: s1_sum_d[i] = ext_a;
            endcase
        end
    end

    always_comb begin
        logic [K:0] s;
        s2_res_d = '0;
        s        = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            s = s1_sum[i];
            unique case (s1_op)
                OpAdd: begin
                    // s - q < 2^K whenever s >= q, so the low K bits carry the full result.
                    if (s >= {1'b0, q}) s2_res_d[i*K +: K] = s[K-1:0] - q;
                    else                s2_res_d[i*K +: K] = s[K-1:0];
                end
                OpSub, OpNeg: begin
                    if (s[K]) s2_res_d[i*K +: K] = s[K-1:0] + q;
                    else      s2_res_d[i*K +: K] = s[K-1:0];
                end
                OpPass:  s2_res_d[i*K +: K] = s[K-1:0];
                default: s2_res_d[i*K +: K] = s[K-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OpAdd;
            s1_tag   <= '0;
            s1_sum   <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= op_e'(in_op);
            s1_tag   <= in_tag;
            s1_sum   <= s1_sum_d;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_tag   <= '0;
        end else if (s1_valid && s2_accept) begin
            s2_valid <= 1'b1;
            s2_res   <= s2_res_d;
            s2_tag   <= s1_tag;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: narrow instance (K=8, LANES=2, q=251) for function and
// handshake behaviour, wide instance (K=54, LANES=4) as a parametrisation smoke test.
module tb_mod_addsub_pipe;

    localparam logic [53:0] Q54 = 54'h3F_FFFF_FFFF_FFDF;  // 2^54 - 33

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  q;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [7:0]  out_tag;
    logic        busy;

    logic         w_in_valid;
    logic         w_in_ready;
    logic [1:0]   w_in_op;
    logic [215:0] w_in_a;
    logic [215:0] w_in_b;
    logic [7:0]   w_in_tag;
    logic         w_out_valid;
    logic [215:0] w_out_res;
    logic [7:0]   w_out_tag;
    logic         w_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0]  t_op  [4];
    logic [15:0] t_a   [4];
    logic [15:0] t_b   [4];
    logic [15:0] t_exp [4];

    always #5 clk = ~clk;

    mod_addsub_pipe #(.K(8), .LANES(2), .TAG_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q         (q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    mod_addsub_pipe #(.K(54), .LANES(4), .TAG_W(8)) dut_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .q         (Q54),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_op     (w_in_op),
        .in_a      (w_in_a),
        .in_b      (w_in_b),
        .in_tag    (w_in_tag),
        .out_valid (w_out_valid),
        .out_ready (1'b1),
        .out_res   (w_out_res),
        .out_tag   (w_out_tag),
        .busy      (w_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single isolated transaction with out_ready high.
    task automatic run_one(input string name, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [7:0] tag, input logic [15:0] exp);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        chk({name, "_rdy"}, 256'(in_ready), 256'(1'b1));
        step();
        in_valid = 1'b0;
        chk({name, "_lat"}, 256'(out_valid), 256'(1'b0));
        step();
        chk({name, "_vld"}, 256'(out_valid), 256'(1'b1));
        chk({name, "_res"}, 256'(out_res), 256'(exp));
        chk({name, "_tag"}, 256'(out_tag), 256'(tag));
        step();
    endtask

    task automatic drive_t(input int i);
        in_op = t_op[i]; in_a = t_a[i]; in_b = t_b[i]; in_tag = 8'h10 + 8'(i);
        in_valid = 1'b1;
    endtask

    initial begin
        t_op[0] = 2'b00; t_a[0] = {8'd2,   8'd1};   t_b[0] = {8'd4,   8'd3};   t_exp[0] = {8'd6,   8'd4};
        t_op[1] = 2'b01; t_a[1] = {8'd100, 8'd5};   t_b[1] = {8'd50,  8'd6};   t_exp[1] = {8'd50,  8'd250};
        t_op[2] = 2'b10; t_a[2] = {8'd0,   8'd0};   t_b[2] = {8'd125, 8'd250}; t_exp[2] = {8'd126, 8'd1};
        t_op[3] = 2'b00; t_a[3] = {8'd126, 8'd125}; t_b[3] = {8'd125, 8'd126}; t_exp[3] = {8'd0,   8'd0};

        rst_n = 1'b0; q = 8'd251; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        in_tag = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_op = 2'b00; w_in_a = '0; w_in_b = '0; w_in_tag = '0;
        step(); step();
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_busy",      256'(busy),      256'(1'b0));
        chk("rst_out_res",   256'(out_res),   256'(16'd0));
        chk("rst_out_tag",   256'(out_tag),   256'(8'd0));
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  256'(in_ready),  256'(1'b1));
        step();

        run_one("add",      2'b00, {8'd5,   8'd200}, {8'd3,   8'd100}, 8'hA5, {8'd8,   8'd49});
        run_one("sub",      2'b01, {8'd250, 8'd3},   {8'd0,   8'd10},  8'h3C, {8'd250, 8'd244});
        run_one("neg",      2'b10, {8'd42,  8'd17},  {8'd1,   8'd0},   8'h01, {8'd250, 8'd0});
        run_one("pass",     2'b11, {8'd9,   8'd7},   {8'd200, 8'd100}, 8'hFF, {8'd9,   8'd7});
        run_one("edge_add", 2'b00, {8'd250, 8'd250}, {8'd250, 8'd250}, 8'h55, {8'd249, 8'd249});
        run_one("edge_sub", 2'b01, {8'd0,   8'd250}, {8'd250, 8'd250}, 8'h66, {8'd1,   8'd0});
        run_one("add_eq_q", 2'b00, {8'd0,   8'd250}, {8'd0,   8'd1},   8'h77, {8'd0,   8'd0});

        // Back-to-back streaming: the output after edge i belongs to transaction i-1.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drive_t(i);
                chk("stream_rdy", 256'(in_ready), 256'(1'b1));
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                chk("stream_vld", 256'(out_valid), 256'(1'b1));
                chk("stream_res", 256'(out_res),   256'(t_exp[i-1]));
                chk("stream_tag", 256'(out_tag),   256'(8'h10 + 8'(i - 1)));
            end
        end
        step();
        chk("stream_drained", 256'(out_valid), 256'(1'b0));

        // Backpressure: fill both stages, hold, then release.
        out_ready = 1'b0;
        drive_t(0);
        step();
        drive_t(1);
        chk("bp_rdy_one_full", 256'(in_ready), 256'(1'b1));
        step();
        drive_t(2);
        chk("bp_vld",       256'(out_valid), 256'(1'b1));
        chk("bp_res0",      256'(out_res),   256'(t_exp[0]));
        chk("bp_rdy_full",  256'(in_ready),  256'(1'b0));
        chk("bp_busy",      256'(busy),      256'(1'b1));
        step();
        chk("bp_hold_res",  256'(out_res),   256'(t_exp[0]));
        chk("bp_hold_tag",  256'(out_tag),   256'(8'h10));
        chk("bp_hold_rdy",  256'(in_ready),  256'(1'b0));
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb",  256'(in_ready),  256'(1'b1));
        step();
        in_valid = 1'b0;
        chk("bp_res1",      256'(out_res),   256'(t_exp[1]));
        chk("bp_tag1",      256'(out_tag),   256'(8'h11));
        step();
        chk("bp_res2",      256'(out_res),   256'(t_exp[2]));
        chk("bp_tag2",      256'(out_tag),   256'(8'h12));
        step();
        chk("bp_empty_vld", 256'(out_valid), 256'(1'b0));
        chk("bp_empty_busy", 256'(busy),     256'(1'b0));

        // Reset with two transactions in flight and output stalled.
        out_ready = 1'b0;
        drive_t(3);
        step();
        drive_t(0);
        step();
        in_valid = 1'b0;
        chk("mid_busy_pre", 256'(busy),      256'(1'b1));
        chk("mid_vld_pre",  256'(out_valid), 256'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_vld_async",  256'(out_valid), 256'(1'b0));
        chk("mid_busy_async", 256'(busy),      256'(1'b0));
        chk("mid_res_async",  256'(out_res),   256'(16'd0));
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_stale", 256'(out_valid), 256'(1'b0));
        end

        // Wide smoke test: add then sub.
        w_in_op = 2'b00; w_in_tag = 8'hC3; w_in_valid = 1'b1;
        w_in_a = {54'd0, 54'd5, Q54 - 54'd1, Q54 - 54'd1};
        w_in_b = {54'd0, 54'd7, 54'd1,       Q54 - 54'd1};
        chk("wide_rdy", 256'(w_in_ready), 256'(1'b1));
        step();
        w_in_valid = 1'b0;
        step();
        chk("wide_add_vld", 256'(w_out_valid), 256'(1'b1));
        chk("wide_add_res", 256'(w_out_res),
            256'({54'd0, 54'd12, 54'd0, Q54 - 54'd2}));
        chk("wide_add_tag", 256'(w_out_tag), 256'(8'hC3));
        w_in_op = 2'b01; w_in_tag = 8'h3C; w_in_valid = 1'b1;
        w_in_a = {54'd3,       Q54 - 54'd1, 54'd7, 54'd0};
        w_in_b = {Q54 - 54'd1, 54'd0,       54'd5, 54'd1};
        step();
        w_in_valid = 1'b0;
        step();
        chk("wide_sub_res", 256'(w_out_res),
            256'({54'd4, Q54 - 54'd1, 54'd2, Q54 - 54'd1}));
        chk("wide_sub_tag", 256'(w_out_tag), 256'(8'h3C));
        step();
        chk("wide_idle", 256'(w_busy), 256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_addsub_pipe.md
# mod_addsub_pipe

Multi-lane modular add/subtract unit with a valid/ready handshake, full-throughput stall-capable pipeline and tag passthrough. It serves as the general modular-arithmetic stage in the ModRing library, used wherever add, subtract, negate or bypass on residues mod q feeds a consumer that may apply backpressure. Each transaction carries LANES independent K-bit operand pairs sharing one modulus and one opcode.

## Interface
- K, 54, operand/modulus width in bits (K ≥ 2)
- LANES, 4, independent lanes per transaction (≥ 1)
- TAG_W, 8, width of opaque sideband tag carried with each transaction (≥ 1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- q  in  K  modulus, 2 ≤ q < 2^K; quasi-static, shared by all lanes
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept input this cycle
- in_op  in  2  00 add, 01 sub, 10 neg, 11 pass
- in_a  in  LANES*K  lane i operand a at bits [i*K +: K]
- in_b  in  LANES*K  lane i operand b, same packing
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  LANES*K  lane results, same packing
- out_tag  out  TAG_W  tag of the transaction in out_res
- busy  out  1  any pipeline stage holds a transaction

## Operation
- Operand precondition: a, b < q. Outputs for out-of-range operands are unspecified but must not lock up the pipeline.
- Transfer occurs on a clock edge with valid && ready, on either side.
- Stage 1 (registered): per lane, compute a (K+1)-bit integer intermediate, and register op and tag.
  - add: s = a + b
  - sub: s = a − b, where bit K is the borrow
  - neg: s = 0 − b
  - pass: s = a
- Stage 2 (registered, drives outputs): per lane correction.
  - add: result = s − q if s ≥ q, else s[K-1:0]
  - sub/neg: result = s[K-1:0] + q if s[K] = 1, else s[K-1:0]
  - pass: result = s[K-1:0]
- neg with b = 0 returns 0, never q.
- Results always lie in [0, q) when the precondition holds.
- All lanes use the same op. Lanes are fully independent and have no carries between them.
- Stall handling:
  - Stage 2 holds while out_valid && !out_ready.
  - Stage 1 advances when stage 2 is empty or stage 2 is transferring.
  - in_ready = !s1_valid || s1_advance. It is combinational from out_ready; no skid buffer is needed.
- Data and tag registers in a holding stage must not change.
- busy = s1_valid || s2_valid.
- q must stay stable while busy = 1. Changing q mid-flight gives unspecified results for in-flight transactions only.

## Timing
- Reset (rst_n = 0, asynchronous): s1_valid = s2_valid = 0, out_valid = 0, busy = 0, out_res = 0, out_tag = 0.
  - in_ready = 1 immediately after reset deassertion.
- Reset mid-operation discards all in-flight transactions. No output is produced for them.
- Latency: input accepted at edge N gives out_valid = 1 after edge N+1. The result is visible in cycle N+2 when no stall occurs.
- Throughput: one transaction per cycle with out_ready held high.
- Backpressure:
  - With out_ready low, at most 2 transactions are held and in_ready drops once both stages are full.
  - On out_ready rising, results emerge back-to-back in acceptance order.
- Simultaneous events: when stages are full and out_ready = 1, output transfer, stage shift and a new input acceptance all occur on the same edge.
- No combinational path from in_* to out_*.

## Test plan
- K=8, LANES=2, q=251, op add, a=(200,5), b=(100,3): result (49,8) two cycles after acceptance, tag preserved.
- op sub, a=(3,250), b=(10,0): (244,250). op neg, b=(0,1): (0,250). op pass, a=(7,9): (7,9).
- Back-to-back streaming of 1000 random legal transactions with out_ready = 1: one result per cycle, matching the reference model ((a±b) mod q), in order.
- Random out_ready toggling (50%) with random in_valid: no loss or duplication, order kept, in_ready = 0 only when both stages are full and the output is stalled, held outputs stable.
- Assert rst_n low with 2 transactions in flight and out_ready low: out_valid/busy drop to 0 asynchronously, and no stale result appears after release.
- Edge values a=b=q−1=250: add gives 249, sub gives 0. a=0, b=250, sub gives 1. Parametrisation smoke test at K=54, LANES=4 with q = 2^54−33.
